// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode/flag widths, opcode encodings and the arbiter FSM state type.
package alu_pkg;
  localparam int ALU_OP_W    = 5;
  localparam int ALU_FLAGS_W = 4;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 5'b00000;
  localparam alu_op_t ALU_SUB   = 5'b00001;
  localparam alu_op_t ALU_AND   = 5'b01010;
  localparam alu_op_t ALU_OR    = 5'b01011;
  localparam alu_op_t ALU_XOR   = 5'b01100;
  localparam alu_op_t ALU_SLL   = 5'b10000;
  localparam alu_op_t ALU_SRL   = 5'b10001;
  localparam alu_op_t ALU_SRA   = 5'b10010;
  localparam alu_op_t ALU_PASSB = 5'b11111;

  // Flag bit positions within the 4-bit flags word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between issue units and alu_arbiter; requester slices are packed side by side.
interface alu_arbiter_if #(
  parameter int W   = 16,
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  import alu_pkg::*;

  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N*ALU_OP_W-1:0]  req_op;
  logic [N*W-1:0]         req_a;
  logic [N*W-1:0]         req_b;
  logic [N-1:0]           req_lock;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic signed [W-1:0]    rsp_result;
  logic [ALU_FLAGS_W-1:0] rsp_flags;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_lock, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_lock, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU datapath; flags are {negative, zero, carry, overflow}. Unknown opcodes yield 0.
module alu import alu_pkg::*; #(
  parameter int W = 16
) (
  input  alu_op_t                alu_op,
  input  logic signed [W-1:0]    operandA,
  input  logic signed [W-1:0]    operandB,
  output logic signed [W-1:0]    resultAccumulator,
  output logic [ALU_FLAGS_W-1:0] flags
);
  localparam int SHW = $clog2(W);

  logic signed [W-1:0] res;
  logic                carry;
  logic                ovf;
  logic [SHW-1:0]      sh;

  assign sh = operandB[SHW-1:0];

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        {carry, res} = {1'b0, operandA} + {1'b0, operandB};
        ovf = (operandA[W-1] == operandB[W-1]) && (res[W-1] != operandA[W-1]);
      end
      ALU_SUB: begin
        {carry, res} = {1'b0, operandA} - {1'b0, operandB};
        ovf = (operandA[W-1] != operandB[W-1]) && (res[W-1] != operandA[W-1]);
      end
      ALU_AND:   res = operandA & operandB;
      ALU_OR:    res = operandA | operandB;
      ALU_XOR:   res = operandA ^ operandB;
      ALU_SLL:   res = operandA << sh;
      ALU_SRL:   res = $signed($unsigned(operandA) >> sh);
      ALU_SRA:   res = operandA >>> sh;
      ALU_PASSB: res = operandB;
      default:   res = '0;
    endcase
  end

  assign resultAccumulator = res;
  assign flags = {res[W-1], (res == '0), carry, ovf};
endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping N-1 -> 0.
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu among N requesters, one operation in flight (IDLE -> EXEC -> RESP).
// Optional ALU_ARB_LOCK_EN lets a locked requester keep the grant for up to 4 operations.
module alu_arbiter import alu_pkg::*; #(
  parameter int W   = 16,
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
);
  alu_arb_state_t state_q, state_d;

  logic [IDW-1:0]         ptr_q, id_q, rsp_id_q;
  alu_op_t                op_q;
  logic signed [W-1:0]    a_q, b_q, rsp_result_q, alu_res;
  logic [ALU_FLAGS_W-1:0] alu_flags, rsp_flags_q;

  logic [N-1:0]   pick_grant, sel_grant;
  logic [IDW-1:0] pick_idx, sel_idx;
  logic           pick_any, sel_any;
  logic           accept;

  alu_op_t             op_arr [N];
  logic signed [W-1:0] a_arr  [N];
  logic signed [W-1:0] b_arr  [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign op_arr[i] = bus.req_op[ALU_OP_W*i +: ALU_OP_W];
    assign a_arr[i]  = bus.req_a[W*i +: W];
    assign b_arr[i]  = bus.req_b[W*i +: W];
  end

  rr_picker #(.N(N), .IDW(IDW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef ALU_ARB_LOCK_EN
  logic       hold_q;
  logic [1:0] lock_cnt_q;

  // A held lock overrides the round-robin pick only while its owner is still asking.
  always_comb begin
    sel_grant = pick_grant;
    sel_idx   = pick_idx;
    sel_any   = pick_any;
    if (hold_q && bus.req_valid[id_q]) begin
      sel_grant       = '0;
      sel_grant[id_q] = 1'b1;
      sel_idx         = id_q;
      sel_any         = 1'b1;
    end
  end

  // The fourth consecutive locked grant releases the lock so others get a turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= 1'b0;
      lock_cnt_q <= 2'd0;
    end else if (accept) begin
      if (bus.req_lock[sel_idx] && lock_cnt_q != 2'd3) begin
        hold_q     <= 1'b1;
        lock_cnt_q <= lock_cnt_q + 2'd1;
      end else begin
        hold_q     <= 1'b0;
        lock_cnt_q <= 2'd0;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
  assign sel_grant   = pick_grant;
  assign sel_idx     = pick_idx;
  assign sel_any     = pick_any;
`endif

  assign accept = (state_q == IDLE) && sel_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = sel_grant;
        if (sel_any) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      id_q         <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      if (accept) begin
        op_q <= op_arr[sel_idx];
        a_q  <= a_arr[sel_idx];
        b_q  <= b_arr[sel_idx];
        id_q <= sel_idx;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= alu_res;
        rsp_flags_q  <= alu_flags;
        rsp_id_q     <= id_q;
      end
      if (state_q == RESP && bus.rsp_ready)
        ptr_q <= (id_q == IDW'(N-1)) ? '0 : id_q + 1'b1;
    end
  end

  alu #(.W(W)) u_alu (
    .alu_op            (op_q),
    .operandA          (a_q),
    .operandB          (b_q),
    .resultAccumulator (alu_res),
    .flags             (alu_flags)
  );

  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single/negative ops, round-robin, backpressure, mid-op reset, lock.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk, rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_g [6];

  alu_arbiter_if #(.W(16), .N(4)) bus ();

  alu_arbiter #(.W(16), .N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] op,
                         input logic signed [15:0] a, input logic signed [15:0] b);
    bus.req_op[5*i +: 5]  = op;
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_lock  = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'h0);
    chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'h0);
    rst = 1'b0;
    #1;

    // Single request: requester 0, OR(-32, 5) = -27
    set_req(0, ALU_OR, -16'sd32, 16'sd5);
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("single_exec_valid", 32'(bus.rsp_valid), 32'h0);
    chk("single_exec_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_result", 32'(bus.rsp_result), 32'(-16'sd27));
    chk("single_id", 32'(bus.rsp_id), 32'h0);
    chk("single_flags", 32'(bus.rsp_flags), 32'h8);
    bus.rsp_ready = 1'b1;
    tick();
    chk("single_done", 32'(bus.rsp_valid), 32'h0);

    // Negative operands: requester 2, OR(-13, -3) = -1
    set_req(2, ALU_OR, -16'sd13, -16'sd3);
    bus.req_valid = 4'b0100;
    #1;
    chk("neg_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("neg_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("neg_result", 32'(bus.rsp_result), 32'(-16'sd1));
    chk("neg_id", 32'(bus.rsp_id), 32'h2);
    chk("neg_flags", 32'(bus.rsp_flags), 32'h8);
    tick();

    // Mid-operation reset: requester 1 (ptr=3 wraps to 1), reset while in EXEC
    set_req(1, ALU_ADD, 16'sd20, -16'sd3);
    bus.req_valid = 4'b0010;
    #1;
    chk("mid_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_result", 32'(bus.rsp_result), 32'h0);
    chk("mid_rst_id", 32'(bus.rsp_id), 32'h0);
    chk("mid_rst_flags", 32'(bus.rsp_flags), 32'h0);
    tick();
    chk("mid_rst_held_valid", 32'(bus.rsp_valid), 32'h0);
    rst = 1'b0;
    #1;
    tick();
    chk("mid_no_rsp", 32'(bus.rsp_valid), 32'h0);

    // Round-robin from ptr 0: ADD(10*(i+1), -3) per requester
    for (int i = 0; i < 4; i++) set_req(i, ALU_ADD, 16'(10 * (i + 1)), -16'sd3);
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_ready%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      tick();
      chk($sformatf("rr_exec%0d", k), 32'(bus.rsp_valid), 32'h0);
      tick();
      chk($sformatf("rr_valid%0d", k), 32'(bus.rsp_valid), 32'h1);
      chk($sformatf("rr_id%0d", k), 32'(bus.rsp_id), 32'(k % 4));
      chk($sformatf("rr_result%0d", k), 32'(bus.rsp_result), 32'(10 * ((k % 4) + 1) - 3));
      chk($sformatf("rr_flags%0d", k), 32'(bus.rsp_flags), 32'h2);
      tick();
    end

    // Backpressure: ptr=1, requester 1 served, rsp_ready low for 10 cycles
    bus.rsp_ready = 1'b0;
    chk("bp_ready", 32'(bus.req_ready), 32'h2);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(bus.rsp_valid), 32'h1);
      chk($sformatf("bp_id%0d", k), 32'(bus.rsp_id), 32'h1);
      chk($sformatf("bp_result%0d", k), 32'(bus.rsp_result), 32'd17);
      chk($sformatf("bp_req_ready%0d", k), 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("bp_resume_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("bp_resume_id", 32'(bus.rsp_id), 32'h2);
    chk("bp_resume_result", 32'(bus.rsp_result), 32'd27);
    tick();

    // Lock: requester 1 locked, requesters 1 and 3 valid, from ptr 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
`ifdef ALU_ARB_LOCK_EN
    exp_g = '{1, 1, 1, 1, 3, 1};
`else
    exp_g = '{1, 3, 1, 3, 1, 3};
`endif
    bus.req_lock  = 4'b0010;
    bus.req_valid = 4'b1010;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("lock_ready%0d", k), 32'(bus.req_ready), 32'(1 << exp_g[k]));
      tick();
      tick();
      chk($sformatf("lock_id%0d", k), 32'(bus.rsp_id), 32'(exp_g[k]));
      chk($sformatf("lock_result%0d", k), 32'(bus.rsp_result), 32'(10 * (exp_g[k] + 1) - 3));
      tick();
    end
    bus.req_valid = 4'b0000;
    bus.req_lock  = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
